// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: divider state encoding and counter sizing.
package arith_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_PREP,
        DIV_ITER,
        DIV_FIX,
        DIV_DONE
    } div_state_e;

    // Iteration counter width for a given operand width (holds WIDTH-1).
    function automatic int unsigned div_cnt_width(input int unsigned width);
        return (width < 3) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational ripple-carry adder: sum_c = a + b + cin, carry out on cout_c.
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_c,
    output logic             cout_c
);

    logic carry;

    always_comb begin
        sum_c = '0;
        carry = cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum_c[i] = a[i] ^ b[i] ^ carry;
            carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout_c = carry;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, signed or unsigned.
// Trial subtractions and the final quotient negation share one ripple-carry adder.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CNT_W = div_cnt_width(WIDTH);
    localparam int unsigned AW    = WIDTH + 1;
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;

    logic [AW-1:0]    rs_c;
    logic [AW-1:0]    add_a_c, add_b_c, add_sum_c;
    logic             add_cout_c;
    logic             a_neg_c, b_neg_c;
    logic             unused_sum_msb;

    ripple_carry_adder #(.WIDTH(AW)) u_adder (
        .a      (add_a_c),
        .b      (add_b_c),
        .cin    (1'b1),
        .sum_c  (add_sum_c),
        .cout_c (add_cout_c)
    );

    assign unused_sum_msb = add_sum_c[AW-1];

    // Shifted partial remainder with the next dividend bit entering the LSB.
    assign rs_c = {r_q, q_q[WIDTH-1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        r_d         = r_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        add_a_c     = rs_c;
        add_b_c     = ~{1'b0, dvs_q};
        a_neg_c     = sgn_q & a_q[WIDTH-1];
        b_neg_c     = sgn_q & b_q[WIDTH-1];

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    a_d     = dividend;
                    b_d     = divisor;
                    sgn_d   = is_signed;
                    busy_d  = 1'b1;
                    state_d = DIV_PREP;
                end
            end
            DIV_PREP: begin
                if (b_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = a_q;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DIV_DONE;
                end else if (sgn_q && (a_q == MIN_INT) && (b_q == '1)) begin
                    quotient_d  = MIN_INT;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b1;
                    done_d      = 1'b1;
                    state_d     = DIV_DONE;
                end else begin
                    // Magnitudes stay unsigned so that |MIN_INT| is representable.
                    q_d     = a_neg_c ? (~a_q + 1'b1) : a_q;
                    dvs_d   = b_neg_c ? (~b_q + 1'b1) : b_q;
                    r_d     = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    q_neg_d = a_neg_c ^ b_neg_c;
                    r_neg_d = a_neg_c;
                    busy_d  = 1'b1;
                    state_d = DIV_ITER;
                end
            end
            DIV_ITER: begin
                busy_d = 1'b1;
                r_d    = add_cout_c ? add_sum_c[WIDTH-1:0] : rs_c[WIDTH-1:0];
                q_d    = {q_q[WIDTH-2:0], add_cout_c};
                if (cnt_q == '0) begin
                    state_d = DIV_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_FIX: begin
                // Adder computes 0 - Q for the quotient sign fix.
                add_a_c     = '0;
                add_b_c     = ~{1'b0, q_q};
                quotient_d  = q_neg_q ? add_sum_c[WIDTH-1:0] : q_q;
                remainder_d = r_neg_q ? (~r_q + 1'b1) : r_q;
                dbz_d       = 1'b0;
                ovf_d       = 1'b0;
                done_d      = 1'b1;
                state_d     = DIV_DONE;
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            r_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            r_q         <= r_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: arithmetic reference model plus directed literal checks.
module tb_seq_restoring_divider;

    localparam int unsigned W        = 32;
    localparam int          LAT_NORM = W + 2;
    localparam int          LAT_SPEC = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        int           e0;
    } req_t;

    req_t exp_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   edges   = 0;
    int   n_push  = 0;
    int   n_done  = 0;
    int   n_abort = 0;
    bit   prev_done = 1'b0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: plain integer division, truncating toward zero in signed mode.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
        longint sa;
        longint sb;
        dz = 1'b0;
        ov = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s && sa == -(64'sd1 <<< (W - 1)) && sb == -1) begin
            q  = a;
            r  = '0;
            ov = 1'b1;
        end else if (s) begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    req_t         cur;
    logic [W-1:0] mq, mr;
    logic         mdz, mov;

    // Every done pulse is matched against the oldest accepted request.
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                n_done++;
                check("done_single_cycle", 64'(prev_done), 64'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_done", 64'd1, 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    model(cur.a, cur.b, cur.s, mq, mr, mdz, mov);
                    check("quotient", 64'(quotient), 64'(mq));
                    check("remainder", 64'(remainder), 64'(mr));
                    check("div_by_zero", 64'(div_by_zero), 64'(mdz));
                    check("overflow", 64'(overflow), 64'(mov));
                    check("latency", 64'(edges - cur.e0), 64'((mdz || mov) ? LAT_SPEC : LAT_NORM));
                    check("busy_at_done", 64'(busy), 64'd0);
                end
            end
            prev_done = done;
        end
    end

    // Called just after a negedge; returns one negedge after the sampling edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        req_t r;
        int   guard;
        guard = 0;
        while ((busy || done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        r.a  = a;
        r.b  = b;
        r.s  = s;
        r.e0 = edges + 1;
        exp_q.push_back(r);
        n_push++;
        @(negedge clk);
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input bit poke, output logic [W-1:0] q, output logic [W-1:0] r,
                             output logic dz, output logic ov);
        int n;
        n = 0;
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        ov = overflow;
        if (!done) begin
            check("done_timeout", 64'd0, 64'd1);
        end else if (poke) begin
            dividend = 32'd999;
            divisor  = 32'd5;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_in_done_ignored", 64'(busy), 64'd0);
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov);
        launch(a, b, s);
        wait_done(1'b0, q, r, dz, ov);
    endtask

    logic [W-1:0] q, r, ra, rb;
    logic         dz, ov, rs;
    int           n0;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run(32'd100, 32'd7, 1'b0, q, r, dz, ov);
        check("u100_7_q", 64'(q), 64'd14);
        check("u100_7_r", 64'(r), 64'd2);
        check("u100_7_flags", 64'({dz, ov}), 64'd0);
        @(negedge clk);
        check("done_pulse_low", 64'(done), 64'd0);

        run(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, dz, ov);
        check("s_m7_2_q", 64'(q), 64'hFFFF_FFFD);
        check("s_m7_2_r", 64'(r), 64'hFFFF_FFFF);
        run(32'd7, 32'hFFFF_FFFE, 1'b1, q, r, dz, ov);
        check("s_7_m2_q", 64'(q), 64'hFFFF_FFFD);
        check("s_7_m2_r", 64'(r), 64'd1);
        run(32'hFFFF_FFFF, 32'd16, 1'b0, q, r, dz, ov);
        check("u_max_16_q", 64'(q), 64'h0FFF_FFFF);
        check("u_max_16_r", 64'(r), 64'd15);

        run(32'd1234, 32'd0, 1'b0, q, r, dz, ov);
        check("dbz_q", 64'(q), 64'hFFFF_FFFF);
        check("dbz_r", 64'(r), 64'd1234);
        check("dbz_flag", 64'(dz), 64'd1);

        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, dz, ov);
        check("ovf_q", 64'(q), 64'h8000_0000);
        check("ovf_r", 64'(r), 64'd0);
        check("ovf_flag", 64'(ov), 64'd1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r, dz, ov);
        check("u_min_q", 64'(q), 64'd0);
        check("u_min_r", 64'(r), 64'h8000_0000);
        check("u_min_flags", 64'({dz, ov}), 64'd0);

        // New operands pulsed while busy and during done must not disturb the result.
        launch(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        dividend = 32'd555;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b1, q, r, dz, ov);
        check("busy_ignore_q", 64'(q), 64'd14);
        check("busy_ignore_r", 64'(r), 64'd2);

        // Abort a division partway through the iterations.
        launch(32'd1000000, 32'd3, 1'b0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_quotient", 64'(quotient), 64'd0);
        check("abort_remainder", 64'(remainder), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        n_abort++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n0 = n_done;
        repeat (50) @(negedge clk);
        check("no_done_after_abort", 64'(n_done - n0), 64'd0);

        for (int i = 0; i < 200; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2, 3:    rb = 32'($urandom_range(1, 20));
                4:       rb = 32'(-$urandom_range(1, 20));
                5:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
            run(ra, rb, rs, q, r, dz, ov);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_per_start", 64'(n_done), 64'(n_push - n_abort));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
